// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor sequencer.
// One bit per clock, LSB first, through a carry/borrow cell.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryBorrow,
  output logic             Overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             mode_r;
  logic             cy;
  logic             a_msb;
  logic             b_msb;

  logic             a;
  logic             b;
  logic             s;
  logic             cn;
  logic             ov;
  logic             last;

  always_comb begin
    a  = sa[0];
    b  = sb[0];
    s  = a ^ b ^ cy;
    cn = 1'b0;
    ov = 1'b0;
    if (mode_r) begin
      cn = (~a & b) | (cy & ~(a ^ b));
      ov = (a_msb != b_msb) && (s != a_msb);
    end else begin
      cn = (a & b) | (cy & (a ^ b));
      ov = (a_msb == b_msb) && (s != a_msb);
    end
    last = (cnt == CW'(WIDTH - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sa          <= '0;
      sb          <= '0;
      sr          <= '0;
      mode_r      <= 1'b0;
      cy          <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      Result      <= '0;
      CarryBorrow <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa     <= A;
            sb     <= B;
            mode_r <= Mode;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            cy     <= 1'b0;
            cnt    <= '0;
            sr     <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {s, sr[WIDTH-1:1]};
          cy  <= cn;
          cnt <= cnt + 1'b1;
          // Visible outputs change only when the final bit lands.
          if (last) begin
            Result      <= {s, sr[WIDTH-1:1]};
            CarryBorrow <= cn;
            Overflow    <= ov;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl (WIDTH=8).
// Stimulus pushes expected results; a negedge monitor checks each done.
module tb_serial_addsub_ctrl;

  typedef struct packed {
    logic [7:0] r;
    logic       cb;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Mode = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] Result;
  logic       CarryBorrow;
  logic       Overflow;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .Mode(Mode),
    .busy(busy),
    .done(done),
    .Result(Result),
    .CarryBorrow(CarryBorrow),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("result", int'(Result), int'(e.r));
        chk("carry_borrow", int'(CarryBorrow), int'(e.cb));
        chk("overflow", int'(Overflow), int'(e.ov));
      end
    end
  end

  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [7:0] r,
                        input logic cb, input logic ov);
    int n;
    int bc;
    @(negedge clk);
    A = a;
    B = b;
    Mode = m;
    start = 1'b1;
    sb_q.push_back('{r: r, cb: cb, ov: ov});
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    Mode = ~m;
    wait_done(n, bc);
    chk("latency", n, 9);
    chk("busy_cycles", bc, 8);
  endtask

  initial begin
    int n;
    int bc;
    int nd;
    int first;
    int prev;

    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(Result), 0);
    chk("rst_cb", int'(CarryBorrow), 0);
    chk("rst_ov", int'(Overflow), 0);
    rst = 1'b0;

    run_op(8'd100, 8'd55,  1'b0, 8'd155, 1'b0, 1'b1);
    run_op(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0);
    run_op(8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1);
    run_op(8'd50,  8'd20,  1'b1, 8'd30,  1'b0, 1'b0);
    run_op(8'd20,  8'd50,  1'b1, 8'd226, 1'b1, 1'b0);
    run_op(8'd128, 8'd1,   1'b1, 8'd127, 1'b0, 1'b1);

    // Second start mid-run must be ignored.
    @(negedge clk);
    A = 8'd3;
    B = 8'd4;
    Mode = 1'b0;
    start = 1'b1;
    sb_q.push_back('{r: 8'd7, cb: 1'b0, ov: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    A = 8'd9;
    B = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    wait_done(n, bc);
    chk("latency_ignored_start", n, 5);

    // Start held through DONE and IDLE: accept after one IDLE cycle.
    A = 8'd1;
    B = 8'd2;
    start = 1'b1;
    sb_q.push_back('{r: 8'd3, cb: 1'b0, ov: 1'b0});
    @(negedge clk);
    chk("idle_gap_busy", int'(busy), 0);
    chk("idle_gap_done", int'(done), 0);
    @(negedge clk);
    chk("accept_after_idle", int'(busy), 1);
    start = 1'b0;
    wait_done(n, bc);
    chk("latency_after_idle", n, 8);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    A = 8'd255;
    B = 8'd1;
    Mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_result", int'(Result), 0);
    chk("async_rst_cb", int'(CarryBorrow), 0);
    chk("async_rst_ov", int'(Overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    run_op(8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0);

    // start tied high: one op per 10 cycles.
    @(negedge clk);
    A = 8'd5;
    B = 8'd3;
    Mode = 1'b1;
    start = 1'b1;
    repeat (3) sb_q.push_back('{r: 8'd2, cb: 1'b0, ov: 1'b0});
    nd = 0;
    bc = 0;
    first = 0;
    prev = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        if (nd == 0) first = i;
        else chk("stream_period", i - prev, 10);
        prev = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("stream_first_done", first, 9);
    chk("stream_done_count", nd, 3);
    chk("stream_busy_cycles", bc, 24);
    repeat (12) @(negedge clk);

    chk("queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
